instr_assembler: RTL and testbench
==================================

# instr_assembler

Byte-to-instruction assembler directly upstream of the opcode controller. It collects bytes from the UART receiver into one 64-bit instruction word. Opcode sits in bits [3:0]; write payload sits in [63:4]. It validates the opcode, applies an inter-byte timeout, and presents the finished word over a valid/ready handshake. Read opcodes complete after one byte. Write opcodes need a full 8-byte word.

## Interface
- WIDTH, 64, instruction word width; multiple of 8; BYTES = WIDTH/8
- TIMEOUT_CYCLES, 50000, consecutive idle cycles in COLLECT before abort; ≥ 2
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  rx_data valid this cycle; single-cycle strobe per byte, no backpressure
- out_instr  output  WIDTH  assembled instruction word
- out_opcode  output  4  equals out_instr[3:0]
- out_valid  output  1  out_instr complete and stable
- out_ready  input  1  downstream consumes word when out_valid & out_ready
- busy  output  1  state ≠ IDLE
- err_opcode  output  1  one-cycle pulse: first byte carried an unsupported opcode
- err_timeout  output  1  one-cycle pulse: collection aborted by timeout
- err_overrun  output  1  one-cycle pulse: byte arrived while in HOLD and was dropped

## Operation
- Opcodes:
  - read: 4 RDEC, 5 RCTL, 6 RMIRQ
  - write: 7 WDEC, 8 WCTL, 9 WMIRQ
  - all other values are invalid
- Byte order is little-endian. Byte k is written to out_instr[8k+7:8k]. Byte 0 carries the opcode in its low nibble; its high nibble is payload bits [7:4].
- IDLE:
  - rx_valid with a read opcode: out_instr ← {zeros, rx_data}; go to HOLD.
  - rx_valid with a write opcode: out_instr ← {zeros, rx_data}; count ← 1; timer ← 0; go to COLLECT.
  - rx_valid with an invalid opcode: byte discarded; err_opcode pulses; stay in IDLE; out_instr unchanged.
- COLLECT:
  - rx_valid: byte written at index count; count++; timer ← 0. When this was byte BYTES-1, go to HOLD.
  - No rx_valid: timer++. When timer == TIMEOUT_CYCLES-1, err_timeout pulses, the partial word is discarded, and the state returns to IDLE.
  - If rx_valid arrives in the same cycle as the would-be timeout, the byte wins and no timeout occurs.
- HOLD:
  - out_valid = 1; out_instr and out_opcode held stable.
  - out_valid & out_ready: go to IDLE.
  - rx_valid in HOLD, including the handshake cycle: byte dropped; err_overrun pulses.
- count width is clog2(BYTES). timer width is clog2(TIMEOUT_CYCLES). Neither counter wraps; both are cleared on every state entry.
- Reset at any point (mid-COLLECT, mid-HOLD) discards all partial or pending data.

## Timing
- Reset values: state IDLE, out_instr 0, out_opcode 0, out_valid 0, busy 0, all err_* 0, count 0, timer 0.
- Latency: final byte sampled at edge N gives out_valid = 1 in the cycle after edge N.
  - Read opcode: out_valid one cycle after the byte.
  - Write opcode: out_valid one cycle after byte 7.
- Handshake is AXI-style:
  - out_valid never drops without a handshake.
  - out_instr never changes while out_valid = 1.
  - The handshake cycle is the last cycle out_valid = 1.
- Back-to-back words: after the handshake, state is IDLE on the next cycle, and a byte in that cycle is accepted. Minimum spacing between consecutive read words is 2 cycles.
- Error pulses:
  - each err_* is registered, exactly 1 cycle, asserted the cycle after the triggering edge;
  - err_opcode and err_timeout are mutually exclusive;
  - err_overrun may repeat on consecutive cycles.
- busy:
  - goes high the cycle after a valid first byte;
  - goes low the cycle after the handshake or timeout.

## Test plan
- Read: rx 0x05 -> next cycle out_valid=1, out_instr=64'h5, out_opcode=5; out_ready=1 -> out_valid=0 the following cycle, busy=0.
- Write: rx 07,00,00,00,78,56,34,12 with 0–3 idle cycles between bytes -> out_instr=64'h12345678_00000007, out_opcode=7, out_valid 1 cycle after last byte.
- Invalid opcode:
  - rx 0x03 -> err_opcode single pulse, no out_valid;
  - rx 0x0A -> same response;
  - then rx 0x04 -> valid read word 64'h4.
- Timeout (TIMEOUT_CYCLES=16): rx 08,AA,BB, then idle.
  - err_timeout pulses after 16 idle cycles; busy drops; no out_valid.
  - A byte on idle cycle 15 instead is accepted, with no timeout.
- Backpressure: complete word 0x06; hold out_ready=0 for 10 cycles while 3 bytes arrive.
  - out_instr stays 64'h6 throughout; err_overrun pulses 3 times.
  - Raise out_ready -> single handshake, then normal operation.
- Reset mid-operation: reset after 4 bytes of a write -> all outputs 0 the next cycle; a fresh 8-byte write then assembles correctly.

Source files
------------

// File: rtl/instr_assembler.sv
// Collects UART bytes little-endian into one instruction word, checks the opcode
// in byte 0, aborts a stalled collection on timeout, and offers the word over valid/ready.
//
// state     | meaning
// S_IDLE    | waiting for the first byte (opcode byte)
// S_COLLECT | write opcode seen, gathering the remaining payload bytes
// S_HOLD    | word complete, out_valid high until the consumer takes it
module instr_assembler #(
  parameter int WIDTH          = 64,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] out_instr,
  output logic [3:0]       out_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             err_opcode,
  output logic             err_timeout,
  output logic             err_overrun
);

  localparam int BYTES = WIDTH / 8;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_BYTE  = CW'(BYTES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_opcode_q, err_opcode_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_overrun_q, err_overrun_d;
  logic             is_read, is_write;

  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    case (rx_data[3:0])
      4'd4, 4'd5, 4'd6: is_read  = 1'b1;
      4'd7, 4'd8, 4'd9: is_write = 1'b1;
      default: begin
        is_read  = 1'b0;
        is_write = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    count_d       = count_q;
    timer_d       = timer_q;
    err_opcode_d  = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (is_read) begin
            instr_d = WIDTH'(rx_data);
            count_d = '0;
            timer_d = '0;
            state_d = S_HOLD;
          end else if (is_write) begin
            instr_d = WIDTH'(rx_data);
            count_d = CW'(1);
            timer_d = '0;
            state_d = S_COLLECT;
          end else begin
            err_opcode_d = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        // A byte arriving on the would-be timeout cycle takes priority.
        if (rx_valid) begin
          instr_d[8*count_q +: 8] = rx_data;
          timer_d = '0;
          if (count_q == LAST_BYTE) begin
            count_d = '0;
            state_d = S_HOLD;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else if (timer_q == TIMER_LAST) begin
          err_timeout_d = 1'b1;
          instr_d       = '0;
          count_d       = '0;
          timer_d       = '0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_HOLD: begin
        if (rx_valid) begin
          err_overrun_d = 1'b1;
        end
        if (out_ready) begin
          count_d = '0;
          timer_d = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      err_opcode_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      err_opcode_q  <= err_opcode_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign out_instr   = instr_q;
  assign out_opcode  = instr_q[3:0];
  assign out_valid   = (state_q == S_HOLD);
  assign busy        = (state_q != S_IDLE);
  assign err_opcode  = err_opcode_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: a byte-queue model is checked every cycle,
// and literal expectations from hand calculation pin down key points.
module tb_instr_assembler;

  localparam int WIDTH = 64;
  localparam int TO    = 16;
  localparam int BYTES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] out_instr;
  logic [3:0]       out_opcode;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             err_opcode;
  logic             err_timeout;
  logic             err_overrun;

  int n_total = 0;
  int n_pass  = 0;

  instr_assembler #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err_opcode (err_opcode),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: bytes of a write being gathered, a held word, and an idle-cycle count.
  logic [7:0]       m_q[$];
  logic [WIDTH-1:0] m_word = '0;
  bit               m_hold = 0;
  bit               m_init = 0;
  bit               m_rst  = 0;
  int               m_idle = 0;
  bit               m_eo, m_et, m_eov;

  always @(posedge clk) begin
    m_eo = 0; m_et = 0; m_eov = 0;
    m_rst = reset;
    if (reset) begin
      m_q.delete();
      m_hold = 0;
      m_idle = 0;
      m_init = 1;
    end else if (m_hold) begin
      if (rx_valid) m_eov = 1;
      if (out_ready) m_hold = 0;
    end else if (m_q.size() == 0) begin
      if (rx_valid) begin
        if (rx_data[3:0] >= 4 && rx_data[3:0] <= 6) begin
          m_word = {56'h0, rx_data};
          m_hold = 1;
        end else if (rx_data[3:0] >= 7 && rx_data[3:0] <= 9) begin
          m_q.push_back(rx_data);
          m_idle = 0;
        end else begin
          m_eo = 1;
        end
      end
    end else begin
      if (rx_valid) begin
        m_q.push_back(rx_data);
        m_idle = 0;
        if (m_q.size() == BYTES) begin
          m_word = '0;
          for (int k = 0; k < BYTES; k++) m_word[8*k +: 8] = m_q[k];
          m_hold = 1;
          m_q.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_et = 1;
          m_q.delete();
        end
      end
    end
    #1;
    if (m_init) begin
      chk("out_valid", 64'(out_valid), 64'(m_hold));
      chk("busy", 64'(busy), 64'(m_hold || (m_q.size() != 0)));
      chk("err_opcode", 64'(err_opcode), 64'(m_eo));
      chk("err_timeout", 64'(err_timeout), 64'(m_et));
      chk("err_overrun", 64'(err_overrun), 64'(m_eov));
      if (m_hold) begin
        chk("out_instr", out_instr, m_word);
        chk("out_opcode", 64'(out_opcode), 64'(m_word[3:0]));
      end
      if (m_rst) begin
        chk("rst_instr", out_instr, 64'h0);
        chk("rst_opcode", 64'(out_opcode), 64'h0);
      end
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit rdy);
    @(negedge clk);
    rx_valid  = v;
    rx_data   = d;
    out_ready = rdy;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic write_word(input logic [63:0] w, input int gap_seed);
    for (int k = 0; k < BYTES; k++) begin
      drive(1, w[8*k +: 8], 0);
      for (int g = 0; g < (k + gap_seed) % 4; g++) drive(0, 8'h00, 0);
    end
    drive(0, 8'h00, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ovr;
    reset = 1; rx_valid = 0; rx_data = 0; out_ready = 0;
    settle();
    chk("lit_reset_instr", out_instr, 64'h0);
    chk("lit_reset_valid", 64'(out_valid), 64'h0);
    chk("lit_reset_busy", 64'(busy), 64'h0);
    @(negedge clk); reset = 0;

    // read opcode
    drive(1, 8'h05, 0); settle();
    chk("lit_read_valid", 64'(out_valid), 64'h1);
    chk("lit_read_instr", out_instr, 64'h5);
    chk("lit_read_opcode", 64'(out_opcode), 64'h5);
    drive(0, 8'h00, 1); settle();
    chk("lit_read_done_valid", 64'(out_valid), 64'h0);
    chk("lit_read_done_busy", 64'(busy), 64'h0);

    // write with 0-3 idle gaps, final byte -> valid next cycle
    for (int k = 0; k < BYTES; k++) begin
      drive(1, 64'h12345678_00000007 >> (8*k), 0);
      if (k == BYTES - 1) begin
        settle();
        chk("lit_write_valid", 64'(out_valid), 64'h1);
        chk("lit_write_instr", out_instr, 64'h12345678_00000007);
        chk("lit_write_opcode", 64'(out_opcode), 64'h7);
      end else begin
        for (int g = 0; g < k % 4; g++) drive(0, 8'h00, 0);
      end
    end
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    // invalid opcodes then a valid read
    drive(1, 8'h03, 0); settle();
    chk("lit_err_opcode_03", 64'(err_opcode), 64'h1);
    drive(0, 8'h00, 0); settle();
    chk("lit_err_opcode_03_end", 64'(err_opcode), 64'h0);
    drive(1, 8'h0A, 0); settle();
    chk("lit_err_opcode_0a", 64'(err_opcode), 64'h1);
    drive(1, 8'h04, 0); settle();
    chk("lit_read4_instr", out_instr, 64'h4);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    // timeout after 16 idle cycles
    drive(1, 8'h08, 0); drive(1, 8'hAA, 0); drive(1, 8'hBB, 0);
    for (int i = 0; i < TO; i++) begin
      drive(0, 8'h00, 0); settle();
      if (i == TO - 2) chk("lit_no_timeout_yet", 64'(err_timeout), 64'h0);
    end
    chk("lit_timeout_pulse", 64'(err_timeout), 64'h1);
    chk("lit_timeout_busy", 64'(busy), 64'h0);
    drive(0, 8'h00, 0); settle();
    chk("lit_timeout_end", 64'(err_timeout), 64'h0);

    // byte on idle cycle 15 wins over the timeout
    drive(1, 8'h08, 0); drive(1, 8'hAA, 0); drive(1, 8'hBB, 0);
    for (int i = 0; i < TO - 1; i++) drive(0, 8'h00, 0);
    drive(1, 8'hCC, 0); settle();
    chk("lit_late_byte_busy", 64'(busy), 64'h1);
    drive(1, 8'hDD, 0); drive(1, 8'hEE, 0); drive(1, 8'hFF, 0); drive(1, 8'h11, 0);
    settle();
    chk("lit_late_word", out_instr, 64'h11FFEEDD_CCBBAA08);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    // backpressure with overruns
    drive(1, 8'h06, 0);
    ovr = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i == 1 || i == 4 || i == 7, 8'h30 + 8'(i), 0); settle();
      if (err_overrun === 1'b1) ovr++;
      chk("lit_bp_instr", out_instr, 64'h6);
    end
    chk("lit_bp_overruns", 64'(ovr), 64'd3);
    drive(0, 8'h00, 1); settle();
    chk("lit_bp_release", 64'(out_valid), 64'h0);
    // handshake with a colliding byte, then an immediate new read
    drive(1, 8'h04, 0);
    drive(1, 8'h55, 1); settle();
    chk("lit_hs_overrun", 64'(err_overrun), 64'h1);
    drive(1, 8'h05, 0); settle();
    chk("lit_b2b_instr", out_instr, 64'h5);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);

    // reset mid-write, then a fresh word
    drive(1, 8'h07, 0); drive(1, 8'h01, 0); drive(1, 8'h02, 0); drive(1, 8'h03, 0);
    @(negedge clk); reset = 1; rx_valid = 0;
    settle();
    chk("lit_midrst_busy", 64'(busy), 64'h0);
    chk("lit_midrst_instr", out_instr, 64'h0);
    @(negedge clk); reset = 0;
    write_word(64'h77665544_33221109, 1);
    chk("lit_after_rst_word", out_instr, 64'h77665544_33221109);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
